// File: rtl/ripple_carry_adder_4bit.sv
// Purpose : registered ripple-carry adder, {cout,sum} = a + b + cin plus signed overflow flag.
// Latency : 1 cycle, inputs sampled at edge k appear on sum/cout/ovf right after edge k.
// Backpressure: none; accepts a new operation every cycle, no handshake or stall.
//
// Ports:
//   clk  in  1      single clock, rising edge
//   rst  in  1      synchronous active-high reset, clears all outputs
//   a    in  WIDTH  operand A (unsigned or two's complement)
//   b    in  WIDTH  operand B
//   cin  in  1      carry into bit 0
//   sum  out WIDTH  registered sum
//   cout out 1      registered carry out of the MSB stage
//   ovf  out 1      registered signed overflow (carry into MSB xor carry out of MSB)

// One-bit full adder cell; the adder is a chain of these.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  logic w_p;

  // Propagate term is shared between the sum and carry paths.
  assign w_p  = i_a ^ i_b;
  assign o_s  = w_p ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & w_p);
endmodule

module ripple_carry_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  // w_carry[i] is the carry into bit i; w_carry[WIDTH] is the carry out of the MSB.
  logic [WIDTH:0]   w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  assign w_carry[0] = cin;

  // Carry ripples LSB to MSB through WIDTH identical cells, no lookahead.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    full_adder_cell u_fa (
      .i_a  (a[gi]),
      .i_b  (b[gi]),
      .i_ci (w_carry[gi]),
      .o_s  (w_sum[gi]),
      .o_co (w_carry[gi+1])
    );
  end

  assign w_cout = w_carry[WIDTH];
  // Signed overflow happens exactly when the carry into the sign bit differs
  // from the carry out of it.
  assign w_ovf  = w_carry[WIDTH] ^ w_carry[WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_cout;
      r_ovf  <= w_ovf;
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_ripple_carry_adder_4bit.sv
// Purpose : self-checking bench for ripple_carry_adder_4bit with directed and exhaustive vectors.
// Latency : every check is taken 1 ns after the edge that registers the result.
// Backpressure: none; inputs change every cycle.
module tb_ripple_carry_adder_4bit;
  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       ovf;

  int checks;
  int failures;

  ripple_carry_adder_4bit #(.WIDTH(4)) u_dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("FAIL %s: got {ovf,cout,sum}=%0h expected %0h", tag, obs, expv);
    end
  endtask

  // Apply one vector, clock it in, then check the registered result.
  task automatic run_vec(input string tag, input logic [3:0] va, input logic [3:0] vb,
                         input logic vc, input logic [3:0] es, input logic ec, input logic eo);
    a   = va;
    b   = vb;
    cin = vc;
    @(posedge clk);
    #1;
    check_val(tag, {26'd0, ovf, cout, sum}, {26'd0, eo, ec, es});
  endtask

  initial begin
    logic [4:0] ref_full;
    logic       ref_ovf;
    logic [3:0] va;
    logic [3:0] vb;
    logic       vc;

    checks   = 0;
    failures = 0;

    // Reset overrides even the max-carry input pattern.
    rst = 1'b1;
    a   = 4'hF;
    b   = 4'hF;
    cin = 1'b1;
    @(posedge clk);
    #1;
    check_val("reset_edge1", {26'd0, ovf, cout, sum}, 32'd0);
    @(posedge clk);
    #1;
    check_val("reset_edge2", {26'd0, ovf, cout, sum}, 32'd0);
    rst = 1'b0;

    // Directed vectors, applied back to back: each result lands one edge later.
    run_vec("zero",        4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    run_vec("5p3_ovf",     4'h5, 4'h3, 1'b0, 4'h8, 1'b0, 1'b1);
    run_vec("1p1",         4'h1, 4'h1, 1'b0, 4'h2, 1'b0, 1'b0);
    run_vec("Ap7_cout",    4'hA, 4'h7, 1'b0, 4'h1, 1'b1, 1'b0);
    run_vec("FpF_cout",    4'hF, 4'hF, 1'b0, 4'hE, 1'b1, 1'b0);
    run_vec("7p8c_ripple", 4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b0);
    run_vec("FpFc_max",    4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    run_vec("zero_again",  4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    run_vec("8p8_negovf",  4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1);
    run_vec("cin_only",    4'h0, 4'h0, 1'b1, 4'h1, 1'b0, 1'b0);

    // Exhaustive sweep against an arithmetic reference, with a reset mid-sweep.
    for (int i = 0; i < 512; i++) begin
      va = i[3:0];
      vb = i[7:4];
      vc = i[8];
      if (i == 300) begin
        rst = 1'b1;
        a   = va;
        b   = vb;
        cin = vc;
        @(posedge clk);
        #1;
        check_val("midsweep_reset", {26'd0, ovf, cout, sum}, 32'd0);
        rst = 1'b0;
      end
      ref_full = {1'b0, va} + {1'b0, vb} + {4'd0, vc};
      ref_ovf  = (va[3] == vb[3]) && (ref_full[3] != va[3]);
      a   = va;
      b   = vb;
      cin = vc;
      @(posedge clk);
      #1;
      check_val($sformatf("sweep_a%0h_b%0h_c%0d", va, vb, vc),
                {26'd0, ovf, cout, sum}, {26'd0, ref_ovf, ref_full});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
